// File: rtl/if_id_block_pkg.sv
// if_id_block_pkg: shared constants, fetch FSM encoding and PC helpers for the fetch stage.
//   RESET_PC_DEF  default PC after reset
//   NOP_INST_DEF  bubble instruction (addi x0,x0,0)
//   fetch_state_e IDLE / REQ / HOLD / DROP
package if_id_block_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction
    function automatic logic [31:0] align4(input logic [31:0] a);
        return a & ~32'd3;
    endfunction
endpackage

// File: rtl/if_id_block_if.sv
// if_id_block_if: instruction-memory read bus between the fetch stage and memory.
//   imem_addr   read address
//   imem_reb    read enable, active-low (low = request outstanding)
//   imem_rdata  instruction word, valid with imem_valid
//   imem_valid  one-cycle response strobe
interface if_id_block_if;
    logic [31:0] imem_addr;
    logic        imem_reb;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    modport master (output imem_addr, imem_reb, input imem_rdata, imem_valid);
    modport slave  (input imem_addr, imem_reb, output imem_rdata, imem_valid);
endinterface

// File: rtl/if_id_block_ifid_reg.sv
// if_id_block_ifid_reg: IF/ID pipeline register with load / bubble / hold controls.
//   load       capture {load_pc, load_inst} as a valid instruction
//   bubble     replace instruction with NOP_INST, clear valid, keep PC
//   neither    hold contents
//   ifid_*     registered outputs to decode
module if_id_block_ifid_reg
    import if_id_block_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_pc    <= 32'h0;
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end else if (load) begin
            ifid_pc    <= load_pc;
            ifid_inst  <= load_inst;
            ifid_valid <= 1'b1;
        end else if (bubble) begin
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/if_id_block.sv
// if_id_block: fetch stage owning the PC, single outstanding imem read, IF/ID register.
//   clk, rst_n     clock and asynchronous active-low reset
//   stall          hold PC and IF/ID contents
//   flush          redirect fetch to branch_target and squash IF/ID; wins over stall
//   branch_target  redirect address, low two bits ignored
//   imem           instruction-memory read bus (master side)
//   ifid_pc/inst/valid  instruction presented to decode
module if_id_block
    import if_id_block_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [31:0]          branch_target,
    if_id_block_if.master        imem,
    output logic [31:0]          ifid_pc,
    output logic [31:0]          ifid_inst,
    output logic                 ifid_valid
);
    fetch_state_e state, state_nxt;
    logic [31:0]  pc, pc_nxt, req_addr, req_nxt, held_inst, held_nxt, load_inst, bt;
    logic         load, bubble;

    assign bt = align4(branch_target);
    assign imem.imem_addr = req_addr;
    assign imem.imem_reb  = !(state == REQ || state == DROP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ:  state_nxt = flush ? (imem.imem_valid ? REQ : DROP)
                                    : (imem.imem_valid && stall ? HOLD : REQ);
            HOLD: state_nxt = (flush || !stall) ? REQ : HOLD;
            DROP: state_nxt = imem.imem_valid ? REQ : DROP;
        endcase
    end

    // A flush with the response still in flight keeps req_addr on the old address
    // so the bus stays stable; DROP swallows that response and then reissues at pc.
    always_comb begin
        pc_nxt    = pc;
        req_nxt   = req_addr;
        held_nxt  = held_inst;
        load      = 1'b0;
        bubble    = 1'b0;
        load_inst = held_inst;
        unique case (state)
            IDLE: begin
                pc_nxt  = flush ? bt : pc;
                req_nxt = flush ? bt : pc;
                bubble  = flush;
            end
            REQ: begin
                if (flush) begin
                    pc_nxt  = bt;
                    req_nxt = imem.imem_valid ? bt : req_addr;
                    bubble  = 1'b1;
                end else if (imem.imem_valid && !stall) begin
                    load      = 1'b1;
                    load_inst = imem.imem_rdata;
                    pc_nxt    = pc_plus4(pc);
                    req_nxt   = pc_plus4(pc);
                end else if (imem.imem_valid) begin
                    held_nxt = imem.imem_rdata;
                end else begin
                    bubble = !stall;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_nxt  = bt;
                    req_nxt = bt;
                    bubble  = 1'b1;
                end else if (!stall) begin
                    load    = 1'b1;
                    pc_nxt  = pc_plus4(pc);
                    req_nxt = pc_plus4(pc);
                end
            end
            DROP: begin
                bubble  = 1'b1;
                pc_nxt  = flush ? bt : pc;
                req_nxt = imem.imem_valid ? (flush ? bt : pc) : req_addr;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            held_inst <= NOP_INST;
        end else begin
            pc        <= pc_nxt;
            req_addr  <= req_nxt;
            held_inst <= held_nxt;
        end
    end

    if_id_block_ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bubble     (bubble),
        .load_pc    (pc),
        .load_inst  (load_inst),
        .ifid_pc    (ifid_pc),
        .ifid_inst  (ifid_inst),
        .ifid_valid (ifid_valid)
    );
endmodule
